mii_frame_gen: RTL

Parametrised MII transmit frame generator.
- Builds complete Ethernet frames on a 4-bit MII in `mii_tx_clk` (25 MHz) domain: preamble/SFD, payload (internal pattern or external byte stream), minimum-length padding, CRC-32 FCS, inter-frame gap.
- Supports multi-frame bursts and error injection.
- Used as PHY-side stimulus for `eth` rx path and as a synthesizable loopback/traffic source on board.

---
 rtl/mii_frame_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mii_frame_gen.sv
// MII (4-bit) Ethernet transmit frame generator: preamble/SFD, patterned or
// streamed payload, zero padding, CRC-32 FCS and inter-frame gap, in bursts.
module mii_frame_gen #(
  parameter int LEN_W       = 11,
  parameter int MAX_LEN     = 1514,
  parameter int MIN_LEN     = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic             mii_tx_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [15:0]      frame_cnt,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             crc_err_inj,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             mii_tx_en,
  output logic             mii_tx_er,
  output logic [3:0]       mii_tx_da,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frames_sent
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, IFG} state_t;
  state_t state, state_nx;

  logic [15:0]      cnt;
  logic [LEN_W-1:0] len_l, pay_l, len_in, pay_in;
  logic [15:0]      fcnt_l, burst_cnt;
  logic [1:0]       mode_l;
  logic [7:0]       seed_l, pat, cur_byte, pat_nx, byte_nx;
  logic             inj_l, cur_er, er_nx, in_pay, more;
  logic [31:0]      crc, fcs;
  logic [LEN_W:0]   next_idx, data_end;
  logic             pre_last, data_last, fcs_last, ifg_last, byte_step;

  function automatic logic [7:0] pat_adv(input logic [1:0] m, input logic [7:0] p);
    case (m)
      2'd0:    pat_adv = p + 8'd1;
      2'd2:    pat_adv = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
      default: pat_adv = p;
    endcase
  endfunction

  // Reflected CRC-32 (0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    pay_in = (int'(frame_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : frame_len;
    len_in = (int'(pay_in) < MIN_LEN) ? LEN_W'(MIN_LEN) : pay_in;
  end

  assign next_idx  = {1'b0, cnt[LEN_W:1]} + (LEN_W+1)'(1);
  assign data_end  = {len_l, 1'b0} - (LEN_W+1)'(1);
  assign pre_last  = (state == PRE)  && (cnt == 16'd15);
  assign data_last = (state == DATA) && (cnt[LEN_W:0] == data_end);
  assign fcs_last  = (state == FCS)  && (cnt == 16'd7);
  assign ifg_last  = (state == IFG)  && (cnt == 16'(IFG_NIBBLES - 1));
  assign byte_step = pre_last || ((state == DATA) && cnt[0]);
  assign more      = !stop && ((fcnt_l == 16'd0) || (burst_cnt != fcnt_l));
  assign fcs       = ~crc;

  always_ff @(posedge mii_tx_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRE;
      PRE:     if (pre_last) state_nx = (len_l == '0) ? FCS : DATA;
      DATA:    if (data_last) state_nx = FCS;
      FCS:     if (fcs_last) state_nx = IFG;
      IFG:     if (ifg_last) state_nx = more ? PRE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next byte: first byte is loaded on the SFD cycle, later ones on each high nibble.
  always_comb begin
    byte_nx = 8'h00;
    er_nx   = 1'b0;
    if (state == PRE) begin
      pat_nx = seed_l;
      in_pay = (pay_l != '0);
    end else begin
      pat_nx = pat_adv(mode_l, pat);
      in_pay = (next_idx < {1'b0, pay_l});
    end
    if (in_pay) begin
      if (mode_l == 2'd3) begin
        byte_nx = s_valid ? s_data : 8'h00;
        er_nx   = !s_valid;
      end else begin
        byte_nx = pat_nx;
      end
    end
  end

  always_comb begin
    mii_tx_en = 1'b0;
    mii_tx_er = 1'b0;
    mii_tx_da = 4'h0;
    case (state)
      PRE: begin
        mii_tx_en = 1'b1;
        mii_tx_da = (cnt == 16'd15) ? 4'hD : 4'h5;
      end
      DATA: begin
        mii_tx_en = 1'b1;
        mii_tx_er = cur_er;
        mii_tx_da = cnt[0] ? cur_byte[7:4] : cur_byte[3:0];
      end
      FCS: begin
        mii_tx_en = 1'b1;
        mii_tx_da = fcs[{cnt[2:0], 2'b00} +: 4] ^ {3'b000, inj_l && (cnt == 16'd0)};
      end
      default: ;
    endcase
  end

  assign s_ready = (mode_l == 2'd3) && byte_step && in_pay;
  assign busy    = (state != IDLE);

  always_ff @(posedge mii_tx_clk) begin
    if (rst) begin
      cnt         <= '0;
      len_l       <= '0;
      pay_l       <= '0;
      fcnt_l      <= '0;
      burst_cnt   <= '0;
      mode_l      <= '0;
      seed_l      <= '0;
      inj_l       <= 1'b0;
      pat         <= '0;
      cur_byte    <= '0;
      cur_er      <= 1'b0;
      crc         <= '1;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || state_nx != state) ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && start) begin
        len_l     <= len_in;
        pay_l     <= pay_in;
        fcnt_l    <= frame_cnt;
        mode_l    <= mode;
        seed_l    <= (mode == 2'd2 && seed == 8'h00) ? 8'h01 : seed;
        inj_l     <= crc_err_inj;
        burst_cnt <= '0;
      end
      if (byte_step) begin
        pat      <= pat_nx;
        cur_byte <= byte_nx;
        cur_er   <= er_nx;
      end
      if (state == PRE)                crc <= '1;
      else if (state == DATA && cnt[0]) crc <= crc_byte(crc, cur_byte);
      if (fcs_last) begin
        frames_sent <= frames_sent + 16'd1;
        burst_cnt   <= burst_cnt + 16'd1;
      end
      if (ifg_last && !more) done <= 1'b1;
    end
  end
endmodule
